// File: rtl/idea_key_sched.sv
// IDEA key schedule: expands a 128-bit key into 16-bit subkeys delivered as 96-bit round bundles.
// Define IDEA_KS_OUTXFORM_EN to also emit the four-subkey output-transform bundle.
module idea_key_sched #(
  parameter int ROT    = 25,
  parameter int NROUND = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         sk_valid,
  input  logic         sk_ready,
  output logic [95:0]  sk_data,
  output logic [3:0]   sk_round,
  output logic         sk_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    EMIT = 2'd2
  } state_t;

`ifdef IDEA_KS_OUTXFORM_EN
  localparam logic [3:0] LAST_ROUND = 4'(NROUND);
`else
  localparam logic [3:0] LAST_ROUND = 4'(NROUND - 1);
`endif

  state_t         state_r;
  state_t         state_next_s;
  logic [127:0]   key_r;
  logic [127:0]   key_rot_s;
  logic [2:0]     w_r;
  logic [2:0]     c_r;
  logic [2:0]     c_inc_s;
  logic [2:0]     target_s;
  logic [79:0]    col_r;
  logic [15:0]    word_s;
  logic [95:0]    bundle_s;
  logic           last_bundle_s;
  logic           gen_done_s;
  logic           key_ready_r;
  logic           sk_valid_r;
  logic [95:0]    sk_data_r;
  logic [3:0]     sk_round_r;
  logic           sk_last_r;

  function automatic logic [15:0] pick_word(input logic [127:0] k, input logic [2:0] w);
    case (w)
      3'd0:    return k[127:112];
      3'd1:    return k[111:96];
      3'd2:    return k[95:80];
      3'd3:    return k[79:64];
      3'd4:    return k[63:48];
      3'd5:    return k[47:32];
      3'd6:    return k[31:16];
      3'd7:    return k[15:0];
      default: return 16'h0000;
    endcase
  endfunction

  assign key_rot_s     = (key_r << ROT) | (key_r >> (128 - ROT));
  assign word_s        = pick_word(key_r, w_r);
  assign c_inc_s       = c_r + 3'd1;
  assign last_bundle_s = (sk_round_r == LAST_ROUND);
  assign gen_done_s    = (state_r == GEN) && (c_inc_s == target_s);

  // Bundle size and assembly of the completed bundle from the collector.
  always_comb begin
    target_s = 3'd6;
    bundle_s = {col_r, word_s};
`ifdef IDEA_KS_OUTXFORM_EN
    if (last_bundle_s) begin
      target_s = 3'd4;
      bundle_s = {col_r[47:0], word_s, 32'h0000_0000};
    end else begin
      target_s = 3'd6;
      bundle_s = {col_r, word_s};
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (key_valid) state_next_s = GEN;
        else           state_next_s = IDLE;
      end
      GEN: begin
        if (gen_done_s) state_next_s = EMIT;
        else            state_next_s = GEN;
      end
      EMIT: begin
        if (sk_ready) state_next_s = last_bundle_s ? IDLE : GEN;
        else          state_next_s = EMIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Key rotation, subkey collection and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r       <= 128'd0;
      w_r         <= 3'd0;
      c_r         <= 3'd0;
      col_r       <= 80'd0;
      key_ready_r <= 1'b1;
      sk_valid_r  <= 1'b0;
      sk_data_r   <= 96'd0;
      sk_round_r  <= 4'd0;
      sk_last_r   <= 1'b0;
    end else begin
      key_ready_r <= (state_next_s == IDLE);
      sk_valid_r  <= (state_next_s == EMIT);
      case (state_r)
        IDLE: begin
          if (key_valid) begin
            key_r <= key_in;
            w_r   <= 3'd0;
            c_r   <= 3'd0;
            col_r <= 80'd0;
          end
        end
        GEN: begin
          // w_r is the subkey index k modulo 8, which is all the datapath needs.
          col_r <= {col_r[63:0], word_s};
          w_r   <= w_r + 3'd1;
          c_r   <= c_inc_s;
          if (w_r == 3'd7) key_r <= key_rot_s;
          if (gen_done_s) begin
            sk_data_r <= bundle_s;
            sk_last_r <= last_bundle_s;
          end
        end
        EMIT: begin
          if (sk_ready) begin
            c_r <= 3'd0;
            if (last_bundle_s) begin
              sk_round_r <= 4'd0;
              sk_last_r  <= 1'b0;
            end else begin
              sk_round_r <= sk_round_r + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign key_ready = key_ready_r;
  assign sk_valid  = sk_valid_r;
  assign sk_data   = sk_data_r;
  assign sk_round  = sk_round_r;
  assign sk_last   = sk_last_r;

endmodule

// File: doc/idea_key_sched.md
# idea_key_sched

Sequential IDEA encryption key-schedule stage that sits directly upstream of `round`. It accepts one 128-bit user key and expands it into 16-bit subkeys by repeated 25-bit left rotation. It delivers the subkeys one round-bundle at a time over a valid/ready handshake: six subkeys per round for rounds 0–7, then four for the output transform. Its `sk_data[95:0]` bundle connects directly to the `key` input of `round`.

## Interface

Parameters:
- `ROT`, default 25: rotate-left amount applied after every 8 subkeys are extracted.
- `NROUND`, default 8: number of full six-subkey rounds.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `key_valid`, in, 1: `key_in` is valid.
- `key_in`, in, 128: user key.
- `key_ready`, out, 1: block idle and able to accept a key.
- `sk_valid`, out, 1: `sk_data` and `sk_round` are valid.
- `sk_ready`, in, 1: downstream consumes the bundle.
- `sk_data`, out, 96: subkey bundle; first subkey in `[95:80]`, sixth in `[15:0]`.
- `sk_round`, out, 4: bundle index, 0..NROUND.
- `sk_last`, out, 1: marks the final bundle of this key.

## Operation

- Reset values: state IDLE, `key_ready`=1, `sk_valid`=0, `sk_data`=0, `sk_round`=0, `sk_last`=0. The internal key register, subkey counter and collector are all cleared.
- States:
  - IDLE: `key_ready`=1. On `key_valid`, load `key_in` into the rotating key register K, clear subkey counter `k` (0..51) and collector count `c`, then go to GEN.
  - GEN: one subkey per cycle. Subkey = word `w=k%8` of K, where word 0 is `K[127:112]` and word 7 is `K[15:0]`. Shift it into the collector MSB-first and increment `k` and `c`. If `w==7`, rotate K left by ROT in the same edge (rotation is a full 128-bit wrap). When `c` reaches 6 (rounds 0..7) or 4 (the output-transform bundle), go to EMIT.
  - EMIT: `sk_valid`=1 and data held stable until `sk_ready`. On the handshake edge:
    - If more bundles remain, increment `sk_round`, clear `c`, and go to GEN.
    - Otherwise go to IDLE.
- Output-transform bundle (`sk_round`=8): subkeys 48..51 occupy `sk_data[95:32]`, and `[31:0]` is 0.
- `key_valid` is ignored outside IDLE. A new key is never accepted while a schedule is in progress.
- `sk_ready` asserted outside EMIT has no effect.
- `rst` asserted in any state aborts the schedule at the next edge and restores all reset values. A partially collected bundle is discarded.

## Timing

- Key accept edge = edge 0. The first `sk_valid` is high after edge 6, so bundle 0 is visible in the cycle following the sixth GEN edge.
- Each six-subkey bundle takes 6 GEN cycles plus at least 1 EMIT cycle, which is 7 cycles per round with `sk_ready` tied high. The four-subkey bundle takes 5.
- With `sk_ready` held high, a full schedule is 8·7 + 5 = 61 cycles from accept to the return to IDLE. `key_ready` rises in the cycle after the final handshake.
- `sk_data`, `sk_round` and `sk_last` are registered and change only on the handshake edge or in GEN. They never change while `sk_valid`=1 and `sk_ready`=0.

## Configuration

- `IDEA_KS_OUTXFORM_EN` defined:
  - Nine bundles (`sk_round` 0..8); 52 subkeys generated.
  - `sk_last`=1 on bundle 8.
- Undefined:
  - Only bundles 0..7 are produced (48 subkeys). The output-transform bundle is never generated.
  - `sk_last`=1 on bundle 7; return to IDLE after its handshake.
  - The 4-subkey path and its logic are omitted.

## Test plan

- **Reset values:** hold `rst` 3 cycles → `key_ready`=1, `sk_valid`=0, `sk_data`=0, `sk_round`=0.
- **Key = 1, bundles 0–2:** load `key_in`=128'h1 with `sk_ready`=1 → expected bundles:
  - bundle 0 = 96'h0;
  - bundle 1 = 96'h0000_0001_0000_0000_0000_0000;
  - bundle 2 = 96'h0000_0000_0200_0000_0000_0000.
- **Key = 1, bundle 4:** same stimulus → bundle 4 = 96'h0000_0000_0000_0800_0000_0000, which is K rotated 75, words 0..5. Feed it to `round` and check against the existing round vector.
- **Backpressure:** hold `sk_ready`=0 for 10 cycles during bundle 3 → `sk_valid` stays 1 with `sk_data` and `sk_round`=3 stable. Pulse `sk_ready` → bundle 4 appears 6 cycles later.
- **Final bundle:** with `IDEA_KS_OUTXFORM_EN` defined, 61-cycle schedule, bundle 8 low 32 bits = 0 and `sk_last`=1. Undefined: the last handshake is bundle 7 with `sk_last`=1.
- **Reset mid-schedule:** assert `rst` during GEN of bundle 5, and pulse `key_valid` while busy → the key is not accepted while busy; after reset the outputs equal their reset values. A new key=1 then reproduces bundle 0 = 96'h0.
